// File: rtl/kmi_pkg.sv
// kmi_pkg: shared state/history enums and counter width for the KMI line arbiter
package kmi_pkg;
  localparam int KMI_CNT_W = 16;
  typedef enum logic [2:0] {IDLE, INHIBIT, TX, RX, GAP} kmi_arb_state_t;
  typedef enum logic [1:0] {LAST_NONE, LAST_TX, LAST_RX} kmi_last_t;
endpackage

// File: rtl/kmi_cycle_counter.sv
// kmi_cycle_counter: saturating 16-bit cycle counter with clear, enable and terminal-count compare
module kmi_cycle_counter
  import kmi_pkg::*;
(
  input  logic                 ref_clk,
  input  logic                 nreset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [KMI_CNT_W-1:0] limit,
  output logic                 tc
);
  logic [KMI_CNT_W-1:0] cnt;
  always_ff @(posedge ref_clk or negedge nreset)
    if (!nreset) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != '1) ? cnt + 1'b1 : cnt;
  assign tc = cnt == limit;
endmodule

// File: rtl/kmi_line_arbiter.sv
// kmi_line_arbiter: KMI clock-line arbiter (inhibit, TX/RX grant, gap); watchdog enabled by KMI_WATCHDOG_EN
module kmi_line_arbiter
  import kmi_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic ref_clk,
  input  logic nreset,
  input  logic tx_req,
  input  logic rx_req,
  input  logic tx_done,
  input  logic rx_done,
  input  logic err_clr,
  output logic kmi_inhibit,
  output logic tx_grant,
  output logic rx_grant,
  output logic received,
  output logic busy,
  output logic timeout_err
);
  kmi_arb_state_t state, state_d;
  kmi_last_t last;
  logic tc, timeout;
  logic [KMI_CNT_W-1:0] limit;
  assign limit = state == INHIBIT ? KMI_CNT_W'(INHIBIT_CYCLES - 1) : KMI_CNT_W'(TIMEOUT_CYCLES - 1);
  kmi_cycle_counter u_cnt (
    .ref_clk(ref_clk),
    .nreset(nreset),
    .clr(state_d != state),
    .en(state != IDLE),
    .limit(limit),
    .tc(tc)
  );
`ifdef KMI_WATCHDOG_EN
  assign timeout = tc && ((state == TX && !tx_done) || (state == RX && !rx_done));
  always_ff @(posedge ref_clk or negedge nreset)
    if (!nreset) timeout_err <= 1'b0;
    else timeout_err <= timeout ? 1'b1 : err_clr ? 1'b0 : timeout_err;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (tx_req && (!rx_req || last != LAST_TX)) ? INHIBIT : rx_req ? RX : IDLE;
      INHIBIT: state_d = tc ? TX : INHIBIT;
      TX:      state_d = (tx_done || timeout) ? GAP : TX;
      RX:      state_d = (rx_done || timeout) ? GAP : RX;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ref_clk or negedge nreset)
    if (!nreset) begin
      state       <= IDLE;
      last        <= LAST_NONE;
      kmi_inhibit <= 1'b0;
      tx_grant    <= 1'b0;
      rx_grant    <= 1'b0;
      received    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      last        <= state_d == GAP ? (state == TX ? LAST_TX : LAST_RX) : last;
      kmi_inhibit <= state_d == INHIBIT;
      tx_grant    <= state_d == TX;
      rx_grant    <= state_d == RX;
      received    <= state == RX && rx_done;
      busy        <= state_d != IDLE;
    end
endmodule

// File: doc/kmi_line_arbiter.md
KMI_LINE_ARBITER -- requirements
Module: kmi_line_arbiter

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 16, giving the number of ref_clk cycles the KMI clock line is held inhibited before a transmit (legal range 1..65535).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit in ref_clk cycles per transfer (legal range 2..65535).
REQ-003 ref_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 tx_req  input  1  level; transmit engine requests the line and holds it high until tx_done.
REQ-006 rx_req  input  1  level; receive engine has detected device activity and holds it high until rx_done.
REQ-007 tx_done  input  1  one-cycle pulse; transmit finished.
REQ-008 rx_done  input  1  one-cycle pulse; receive finished.
REQ-009 err_clr  input  1  one-cycle pulse; clears timeout_err.
REQ-010 kmi_inhibit  output  1  drives the KMI clock line low.
REQ-011 tx_grant  output  1  transmit engine owns the line.
REQ-012 rx_grant  output  1  receive engine owns the line.
REQ-013 received  output  1  one-cycle pulse on receive completion.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-016 All outputs SHALL be registered; the state machine SHALL have exactly the states IDLE, INHIBIT, TX, RX, GAP.
REQ-017 In IDLE with only tx_req high, the next state SHALL be INHIBIT; with only rx_req high, it SHALL be RX.
REQ-018 In IDLE with both requests high, TX SHALL win unless the last completed grant was TX, in which case RX SHALL win (one-deep anti-starvation).
REQ-019 kmi_inhibit SHALL be high for exactly INHIBIT_CYCLES consecutive cycles in INHIBIT, then the state SHALL be TX with tx_grant high from the following cycle.
REQ-020 In TX, tx_grant SHALL stay high until tx_done is sampled; the next state SHALL be GAP.
REQ-021 In RX, rx_grant SHALL stay high until rx_done is sampled; the next state SHALL be GAP and received SHALL pulse high for exactly one cycle in the cycle after rx_done.
REQ-022 GAP SHALL last exactly one cycle with no grant, then return to IDLE; requests seen in GAP are arbitrated in IDLE.
REQ-023 tx_done or rx_done not matching the current state SHALL be ignored, including when both arrive in the same cycle.
REQ-024 tx_grant, rx_grant and kmi_inhibit SHALL be mutually exclusive (at most one high in any cycle).
REQ-025 A request deasserted before its grant SHALL NOT abort INHIBIT; the sequence completes and relies on done or the watchdog.
REQ-026 The internal cycle counter SHALL be 16 bits, reload to zero on every state entry and never wrap.

Reset
REQ-027 While nreset is low, all outputs SHALL be 0, state SHALL be IDLE, last-grant history SHALL be "none" (TX wins the first tie), and counters SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL drop grants and kmi_inhibit immediately (asynchronously) with no received pulse.

Configuration
REQ-029 With KMI_WATCHDOG_EN defined, a transfer in TX or RX reaching TIMEOUT_CYCLES cycles without its done SHALL force GAP, set timeout_err, and record no received pulse.
REQ-030 With KMI_WATCHDOG_EN defined, timeout_err SHALL clear on err_clr; if err_clr and a new timeout coincide, set SHALL win.
REQ-031 Without KMI_WATCHDOG_EN, transfers SHALL wait indefinitely for done, timeout_err SHALL be tied to 0, and err_clr SHALL be ignored.

Structure
REQ-032 Package kmi_pkg SHALL hold the state enum (kmi_arb_state_t), the last-grant enum, and the counter width constant KMI_CNT_W = 16.
REQ-033 One sub-module, kmi_cycle_counter (clear, enable, terminal-count compare), SHALL be shared by the inhibit and watchdog timing.

Verification (INHIBIT_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-034 tx_req high at cycle 0 -> kmi_inhibit high in cycles 1-4, tx_grant high from cycle 5; tx_done at cycle 8 -> tx_grant low at cycle 9, busy low at cycle 10.
REQ-035 rx_req high, rx_done 3 cycles after rx_grant -> received is a single-cycle pulse one cycle after rx_done, rx_grant then low.
REQ-036 tx_req and rx_req both high from reset -> TX served first; with both still high after GAP -> RX served next, then TX.
REQ-037 Watchdog build, tx_req with no tx_done -> tx_grant drops after 20 cycles in TX, timeout_err=1 until err_clr pulse, then 0.
REQ-038 nreset pulsed low during TX -> all outputs 0 within the reset cycle; after release, tx_req high restarts the full 4-cycle inhibit.
